// File: rtl/mem_access_pkg.sv
// Shared types, access-size codes and helpers for the data-memory access unit.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0] MASK_B = 2'b00;
   localparam logic [1:0] MASK_H = 2'b01;
   localparam logic [1:0] MASK_W = 2'b10;

   localparam int unsigned TIMEOUT_DEFAULT = 255;
   localparam int unsigned TIMEOUT_MAX     = 65535;

   // Watchdog counter width: enough to hold the limit, kept within 8..16 bits.
   function automatic int unsigned timeout_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      if (w < 8) begin
         w = 8;
      end else if (w > 16) begin
         w = 16;
      end
      return w;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v,
                                          input logic [1:0]  mask,
                                          input logic        sgn);
      logic [31:0] r;
      r = v;
      unique case (mask)
         MASK_B:        r = {{24{sgn & v[7]}}, v[7:0]};
         MASK_H:        r = {{16{sgn & v[15]}}, v[15:0]};
         MASK_W, 2'b11: r = v;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables, store-lane replication,
// load extract/extend and misalignment detection.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  mask,
   input  logic [1:0]  addr_lo,
   input  logic        sgn,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ldata,
   output logic        misalign
);

   logic [31:0] shifted;

   always_comb begin
      shifted   = rdata >> {addr_lo, 3'b000};
      be        = 4'b1111;
      wdata_rep = wdata;
      misalign  = 1'b0;
      unique case (mask)
         MASK_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         MASK_H: begin
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
         end
         MASK_W, 2'b11: begin
            misalign = |addr_lo;
         end
      endcase
      ldata = extend(shifted, mask, sgn);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: FSM driving a valid/ready bus with registered request outputs.
// Optional watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ld_en_i,
   input  logic              dram_we_i,
   input  logic [1:0]        mask_op_i,
   input  logic              sign_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic              bus_err_o,
   output logic              bus_req_o,
   input  logic              bus_gnt_i,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_rvalid_i,
   input  logic [31:0]       bus_rdata_i
);

   state_t      state;
   logic        access;
   logic        expire;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] ldata;
   logic        misalign;

   assign access  = ld_en_i | dram_we_i;
   assign stall_o = access & (state != DONE);

   // Decoder controls and address are held by the stall, so the live inputs
   // remain valid for the load extract when read data returns.
   mem_lane_align u_lane (
      .mask      (mask_op_i),
      .addr_lo   (addr_i[1:0]),
      .sgn       (sign_i),
      .wdata     (wdata_i),
      .rdata     (bus_rdata_i),
      .be        (be),
      .wdata_rep (wdata_rep),
      .ldata     (ldata),
      .misalign  (misalign)
   );

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > TIMEOUT_MAX) begin : g_bad_timeout
      $error("mem_access_unit: TIMEOUT_CYCLES out of range");
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int unsigned CNT_W = timeout_width(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             waiting;

   assign busy    = (state == REQ) | (state == WAIT);
   assign waiting = ((state == REQ) & ~bus_gnt_i) | ((state == WAIT) & ~bus_rvalid_i);
   // Count spans REQ and WAIT together; >= keeps a limit crossed on a grant cycle effective.
   assign expire  = waiting & (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt       <= '0;
         bus_err_o <= 1'b0;
      end else begin
         bus_err_o <= expire;
         if (busy && !expire) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end
`else
   assign expire    = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
         rdata_o     <= '0;
         misalign_o  <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (access) begin
                  if (misalign) begin
                     state      <= DONE;
                     misalign_o <= 1'b1;
                     if (!dram_we_i) begin
                        rdata_o <= '0;
                     end
                  end else begin
                     state       <= REQ;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= dram_we_i;
                     bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                     bus_be_o    <= be;
                     bus_wdata_o <= wdata_rep;
                  end
               end
            end
            REQ: begin
               if (bus_gnt_i) begin
                  state     <= bus_we_o ? DONE : WAIT;
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
               end else if (expire) begin
                  state     <= DONE;
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
                  if (!bus_we_o) begin
                     rdata_o <= '0;
                  end
               end
            end
            WAIT: begin
               if (bus_rvalid_i) begin
                  state   <= DONE;
                  rdata_o <= ldata;
               end else if (expire) begin
                  state   <= DONE;
                  rdata_o <= '0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        ld_en;
   logic        dram_we;
   logic [1:0]  mask_op;
   logic        sgn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign;
   logic        bus_err;
   logic        bus_req;
   logic        bus_gnt;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int          checks;
   int          errors;
   logic [31:0] last_rdata;

   mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .ld_en_i      (ld_en),
      .dram_we_i    (dram_we),
      .mask_op_i    (mask_op),
      .sign_i       (sgn),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .rdata_o      (rdata),
      .stall_o      (stall),
      .misalign_o   (misalign),
      .bus_err_o    (bus_err),
      .bus_req_o    (bus_req),
      .bus_gnt_i    (bus_gnt),
      .bus_we_o     (bus_we),
      .bus_addr_o   (bus_addr),
      .bus_be_o     (bus_be),
      .bus_wdata_o  (bus_wdata),
      .bus_rvalid_i (bus_rvalid),
      .bus_rdata_i  (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: access size in bytes, offset arithmetic, explicit sign extension.
   function automatic void model(input logic [31:0] a, input logic [1:0] m, input logic s,
                                 input logic [31:0] wd, input logic [31:0] raw,
                                 output logic mis, output logic [3:0] be,
                                 output logic [31:0] wrep, output logic [31:0] ld);
      int unsigned      size;
      int unsigned      off;
      longint unsigned  v;
      size = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
      off  = a % 4;
      mis  = (a % size) != 0;
      be   = 4'(((1 << size) - 1) << off);
      wrep = '0;
      for (int i = 0; i < 4; i++) begin
         wrep = wrep | (((wd >> (8 * (i % size))) & 32'hFF) << (8 * i));
      end
      v = (longint'(raw) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
      if (s && v >= (64'd1 << (8 * size - 1))) begin
         v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
      end
      ld = 32'(v);
   endfunction

   task automatic do_access(input string name, input logic l, input logic w,
                            input logic [1:0] m, input logic s, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] raw,
                            input int unsigned gd, input int unsigned rd);
      logic        mis;
      logic [3:0]  be;
      logic [31:0] wrep;
      logic [31:0] ld_exp;
      int unsigned stalls;
      int unsigned exp_stalls;
      model(a, m, s, wd, raw, mis, be, wrep, ld_exp);
      ld_en = l; dram_we = w; mask_op = m; sgn = s; addr = a; wdata = wd;
      #1;
      stalls = 0;
      if (stall) stalls++;
      step();
      if (mis) begin
         check({name, ".misalign"}, 32'(misalign), 32'd1);
         check({name, ".noreq"}, 32'(bus_req), 32'd0);
         if (!w) last_rdata = '0;
         exp_stalls = 1;
      end else begin
         check({name, ".req"}, 32'(bus_req), 32'd1);
         check({name, ".we"}, 32'(bus_we), 32'(w));
         check({name, ".addr"}, bus_addr, {a[31:2], 2'b00});
         check({name, ".be"}, 32'(bus_be), 32'(be));
         check({name, ".wdata"}, bus_wdata, wrep);
         for (int i = 0; i < int'(gd); i++) begin
            if (stall) stalls++;
            bus_rvalid = 1'($urandom);
            bus_rdata  = ~raw;
            step();
            check({name, ".req_hold"}, 32'(bus_req), 32'd1);
         end
         bus_rvalid = 1'b0;
         if (stall) stalls++;
         bus_gnt = 1'b1;
         step();
         bus_gnt = 1'b0;
         check({name, ".req_drop"}, 32'(bus_req), 32'd0);
         if (!w) begin
            for (int i = 0; i < int'(rd); i++) begin
               if (stall) stalls++;
               bus_gnt   = 1'($urandom);
               bus_rdata = $urandom;
               step();
            end
            bus_gnt = 1'b0;
            if (stall) stalls++;
            bus_rvalid = 1'b1;
            bus_rdata  = raw;
            step();
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            last_rdata = ld_exp;
         end
         exp_stalls = 1 + gd + 1 + (w ? 0 : rd + 1);
      end
      check({name, ".done_stall"}, 32'(stall), 32'd0);
      check({name, ".stall_cycles"}, stalls, exp_stalls);
      check({name, ".rdata"}, rdata, last_rdata);
      check({name, ".bus_err"}, 32'(bus_err), 32'd0);
      ld_en = 1'b0; dram_we = 1'b0;
      step();
      check({name, ".misalign_clr"}, 32'(misalign), 32'd0);
      check({name, ".rdata_hold"}, rdata, last_rdata);
   endtask

   initial begin
      checks = 0; errors = 0; last_rdata = '0;
      rst_n = 1'b0; ld_en = 1'b0; dram_we = 1'b0; mask_op = 2'b00; sgn = 1'b0;
      addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      step();
      step();
      check("rst.req", 32'(bus_req), 32'd0);
      check("rst.we", 32'(bus_we), 32'd0);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.misalign", 32'(misalign), 32'd0);
      check("rst.bus_err", 32'(bus_err), 32'd0);
      check("rst.rdata", rdata, 32'd0);
      check("rst.addr", bus_addr, 32'd0);
      check("rst.be", 32'(bus_be), 32'd0);
      check("rst.wdata", bus_wdata, 32'd0);
      rst_n = 1'b1;
      step();

      do_access("st_word", 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1, 0);
      do_access("st_byte", 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 32'h0, 0, 0);
      do_access("ld_half_s", 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_0000, 1, 2);
      do_access("ld_half_u", 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8001_0000, 0, 1);
      do_access("ld_byte", 1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000_7F00, 0, 0);
      do_access("ld_mis_w", 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hDEAD_BEEF, 0, 0);
      do_access("ld_word", 1'b1, 1'b0, 2'b11, 1'b1, 32'h2000, 32'h0, 32'hCAFE_F00D, 2, 0);
      do_access("st_half_mis", 1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'h1234, 32'h0, 0, 0);
      do_access("ld_st_both", 1'b1, 1'b1, 2'b01, 1'b1, 32'h302, 32'hBEEF, 32'h5555_5555, 1, 0);

      for (int n = 0; n < 40; n++) begin
         logic [1:0] kind;
         kind = 2'($urandom_range(0, 2));
         do_access("rand", kind != 2'd1, kind != 2'd0, 2'($urandom_range(0, 3)), 1'($urandom),
                   $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Stray handshakes while idle must be ignored.
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = ~last_rdata;
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      check("idle.stray_req", 32'(bus_req), 32'd0);
      check("idle.stray_rdata", rdata, last_rdata);

      // Reset while a request is pending.
      ld_en = 1'b1; dram_we = 1'b0; mask_op = 2'b10; addr = 32'h400;
      step();
      check("rst_req.req_before", 32'(bus_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_req.req", 32'(bus_req), 32'd0);
      check("rst_req.addr", bus_addr, 32'd0);
      ld_en = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Reset while waiting for read data; the late rvalid must be ignored.
      do_access("pre_wait", 1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h1357_9BDF, 0, 0);
      ld_en = 1'b1; addr = 32'h600; mask_op = 2'b10;
      step();
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      check("rst_wait.in_wait", 32'(stall), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      ld_en = 1'b0;
      #1;
      check("rst_wait.req", 32'(bus_req), 32'd0);
      check("rst_wait.stall", 32'(stall), 32'd0);
      check("rst_wait.rdata", rdata, 32'd0);
      step();
      rst_n = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_rvalid = 1'b0;
      check("rst_wait.late_rvalid", rdata, 32'd0);
      check("rst_wait.idle_req", 32'(bus_req), 32'd0);
      last_rdata = '0;
      do_access("post_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h703, 32'h0, 32'h9A00_0000, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
